// File: rtl/sobel_grad_dir_if.sv
// Pixel-column stream into the Sobel stage and gradient stream out of it.
//   valid_in        : din1..din3 carry one column this cycle
//   din1/din2/din3  : top/middle/bottom row pixels (unsigned)
//   mode            : 0 = L1 magnitude, 1 = L-inf magnitude
//   valid_out       : dout valid this cycle
//   eol_out         : last dout of a line
//   dout            : {mag[WIDTH-1:0], dir[1:0]}
interface sobel_grad_dir_if #(
  parameter int unsigned WIDTH = 8
);
  logic               valid_in;
  logic [WIDTH-1:0]   din1;
  logic [WIDTH-1:0]   din2;
  logic [WIDTH-1:0]   din3;
  logic               mode;
  logic               valid_out;
  logic               eol_out;
  logic [WIDTH+1:0]   dout;

  modport master (
    output valid_in, din1, din2, din3, mode,
    input  valid_out, eol_out, dout
  );

  modport slave (
    input  valid_in, din1, din2, din3, mode,
    output valid_out, eol_out, dout
  );
endinterface

// File: rtl/sobel_grad_dir.sv
// 3x3 Sobel gradient stage: three vertically aligned pixel streams in,
// saturated gradient magnitude plus 2-bit quantised direction out.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of sobel_grad_dir_if (column stream in, result out)
// Pipeline: window shift (t) -> Gx/Gy (t+1) -> |Gx|,|Gy| (t+2) -> dout (t+3).
module sobel_grad_dir #(
  parameter int unsigned PIC_WIDTH = 250,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  sobel_grad_dir_if.slave  bus
);

  localparam int unsigned GW = WIDTH + 3;   // signed gradient
  localparam int unsigned AW = WIDTH + 2;   // absolute gradient
  localparam int unsigned SW = WIDTH + 3;   // |Gx|+|Gy| before saturation
  localparam int unsigned PW = WIDTH + 12;  // constant-multiply products
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIC_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_WIN  = CNT_W'(2);
  localparam logic [WIDTH-1:0] MAG_MAX  = '1;

  // Window rows; index 0 newest (right), index 2 oldest (left).
  logic [2:0][WIDTH-1:0] r1, r2, r3;
  logic [CNT_W-1:0]      cnt;
  logic                  w_valid, w_eol;

  logic                  s1_valid, s1_eol, s1_mode;
  logic signed [GW-1:0]  s1_gx, s1_gy;

  logic                  s2_valid, s2_eol, s2_mode, s2_same;
  logic [AW-1:0]         s2_ax, s2_ay;

  logic signed [GW-1:0]  gx_c, gy_c;
  logic [AW-1:0]         ax_c, ay_c;
  logic [SW-1:0]         sel_c;
  logic [WIDTH-1:0]      mag_c;
  logic [1:0]            dir_c;
  logic [PW-1:0]         ay256_c, ax106_c, ax618_c;

  function automatic logic signed [GW-1:0] sx(input logic [WIDTH-1:0] p);
    return $signed(GW'(p));
  endfunction

  // Window shift, column counter and window-complete flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1      <= '0;
      r2      <= '0;
      r3      <= '0;
      cnt     <= '0;
      w_valid <= 1'b0;
      w_eol   <= 1'b0;
    end else begin
      w_valid <= bus.valid_in && (cnt >= CNT_WIN);
      w_eol   <= bus.valid_in && (cnt == CNT_LAST);
      if (bus.valid_in) begin
        r1  <= {r1[1], r1[0], bus.din1};
        r2  <= {r2[1], r2[0], bus.din2};
        r3  <= {r3[1], r3[0], bus.din3};
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      end else begin
        // A gap restarts the line; the partial line is dropped.
        cnt <= '0;
      end
    end
  end

  // Sobel kernels on the current window.
  always_comb begin
    gx_c = (sx(r1[0]) + (sx(r2[0]) <<< 1) + sx(r3[0]))
         - (sx(r1[2]) + (sx(r2[2]) <<< 1) + sx(r3[2]));
    gy_c = (sx(r1[2]) + (sx(r1[1]) <<< 1) + sx(r1[0]))
         - (sx(r3[2]) + (sx(r3[1]) <<< 1) + sx(r3[0]));
  end

  // Stage 1: signed gradients; mode travels with the data from here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_eol   <= 1'b0;
      s1_mode  <= 1'b0;
      s1_gx    <= '0;
      s1_gy    <= '0;
    end else begin
      s1_valid <= w_valid;
      s1_eol   <= w_eol;
      s1_mode  <= bus.mode;
      s1_gx    <= gx_c;
      s1_gy    <= gy_c;
    end
  end

  // Absolute values; |-1024| cannot occur, so AW bits suffice.
  always_comb begin
    ax_c = s1_gx[GW-1] ? AW'($unsigned(-s1_gx)) : AW'($unsigned(s1_gx));
    ay_c = s1_gy[GW-1] ? AW'($unsigned(-s1_gy)) : AW'($unsigned(s1_gy));
  end

  // Stage 2: magnitudes and sign agreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_eol   <= 1'b0;
      s2_mode  <= 1'b0;
      s2_same  <= 1'b0;
      s2_ax    <= '0;
      s2_ay    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_eol   <= s1_eol;
      s2_mode  <= s1_mode;
      s2_same  <= (s1_gx[GW-1] == s1_gy[GW-1]);
      s2_ax    <= ax_c;
      s2_ay    <= ay_c;
    end
  end

  // Magnitude select/saturate and direction binning via tan(22.5)~106/256,
  // tan(67.5)~618/256.
  always_comb begin
    sel_c   = s2_mode ? ((s2_ax >= s2_ay) ? SW'(s2_ax) : SW'(s2_ay))
                      : SW'(s2_ax) + SW'(s2_ay);
    mag_c   = (sel_c > SW'(MAG_MAX)) ? MAG_MAX : WIDTH'(sel_c);
    ay256_c = PW'(s2_ay) << 8;
    ax106_c = PW'(s2_ax) * PW'(106);
    ax618_c = PW'(s2_ax) * PW'(618);
    dir_c   = 2'd3;
    // Strict compare alone would send a zero gradient to bin 1.
    if ((ay256_c < ax106_c) || ((s2_ax == '0) && (s2_ay == '0))) begin
      dir_c = 2'd0;
    end else if (ay256_c > ax618_c) begin
      dir_c = 2'd2;
    end else if (s2_same) begin
      dir_c = 2'd1;
    end
  end

  // Output register; dout holds while no result is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid_out <= 1'b0;
      bus.eol_out   <= 1'b0;
      bus.dout      <= '0;
    end else begin
      bus.valid_out <= s2_valid;
      bus.eol_out   <= s2_valid && s2_eol;
      if (s2_valid) begin
        bus.dout <= {mag_c, dir_c};
      end
    end
  end

endmodule

// File: tb/tb_sobel_grad_dir.sv
// Directed bench for sobel_grad_dir (PIC_WIDTH=8, WIDTH=8).
module tb_sobel_grad_dir;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned PW    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_grad_dir_if #(.WIDTH(WIDTH)) bus ();

  sobel_grad_dir #(.PIC_WIDTH(PW), .WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [WIDTH+1:0] dout_q[$];
  logic             eol_q[$];
  int               cyc_q[$];

  // Capture every presented result with the number of the edge it followed.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.valid_out === 1'b1) begin
      dout_q.push_back(bus.dout);
      eol_q.push_back(bus.eol_out);
      cyc_q.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one column; returns the edge number that samples it.
  task automatic beat(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, output int t);
    @(negedge clk);
    bus.valid_in = v;
    bus.din1     = a;
    bus.din2     = b;
    bus.din3     = c;
    t = cyc + 1;
  endtask

  task automatic idle(input int n);
    int t;
    repeat (n) beat(1'b0, 8'd0, 8'd0, 8'd0, t);
  endtask

  task automatic clear_q();
    dout_q.delete();
    eol_q.delete();
    cyc_q.delete();
  endtask

  // Compare queued result idx against hand-computed mag/dir/eol/edge.
  task automatic check_out(input string tag, input int idx, input int mag, input int dir,
                           input logic eol, input int t_exp);
    if (idx >= dout_q.size()) begin
      check_eq({tag, "_missing"}, dout_q.size(), idx + 1);
    end else begin
      check_eq({tag, "_dout"}, dout_q[idx], (mag << 2) | dir);
      check_eq({tag, "_eol"}, eol_q[idx], eol);
      check_eq({tag, "_time"}, cyc_q[idx], t_exp);
    end
  endtask

  function automatic logic [7:0] step_px(input int col);
    return (col >= 4) ? 8'd255 : 8'd0;
  endfunction

  function automatic logic [7:0] dot_px(input int col);
    return (col == 2) ? 8'd20 : 8'd0;
  endfunction

  int t, t0, t2;
  int em[6];
  int ed[6];

  initial begin
    bus.valid_in = 1'b0;
    bus.din1 = '0;
    bus.din2 = '0;
    bus.din3 = '0;
    bus.mode = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("reset_valid", bus.valid_out, 0);
    check_eq("reset_eol", bus.eol_out, 0);
    check_eq("reset_dout", bus.dout, 0);
    rst_n = 1'b1;
    idle(2);
    clear_q();

    // Flat image, two lines back-to-back.
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, 8'd100, 8'd100, 8'd100, t);
      if (i == 0) t0 = t;
    end
    idle(6);
    check_eq("flat_count", dout_q.size(), 12);
    for (int i = 0; i < 12; i++)
      check_out($sformatf("flat%0d", i), i, 0, 0, (i % 6) == 5, t0 + (i / 6) * 8 + 2 + (i % 6) + 3);
    clear_q();

    // Vertical step.
    for (int c = 0; c < 8; c++) begin
      beat(1'b1, step_px(c), step_px(c), step_px(c), t);
      if (c == 0) t0 = t;
    end
    idle(6);
    em = '{0, 0, 255, 255, 0, 0};
    check_eq("vstep_count", dout_q.size(), 6);
    for (int j = 0; j < 6; j++)
      check_out($sformatf("vstep%0d", j), j, em[j], 0, j == 5, t0 + 2 + j + 3);
    clear_q();

    // Horizontal edge.
    for (int c = 0; c < 8; c++) begin
      beat(1'b1, 8'd255, 8'd0, 8'd0, t);
      if (c == 0) t0 = t;
    end
    idle(6);
    check_eq("hedge_count", dout_q.size(), 6);
    for (int j = 0; j < 6; j++)
      check_out($sformatf("hedge%0d", j), j, 255, 2, j == 5, t0 + 2 + j + 3);
    clear_q();

    // Single pixel, L1 then L-inf.
    for (int m = 0; m < 2; m++) begin
      bus.mode = m[0];
      for (int c = 0; c < 8; c++) begin
        beat(1'b1, dot_px(c), 8'd0, 8'd0, t);
        if (c == 0) t0 = t;
      end
      idle(6);
      if (m == 0) em = '{40, 40, 40, 0, 0, 0};
      else        em = '{20, 40, 20, 0, 0, 0};
      ed = '{1, 2, 3, 0, 0, 0};
      check_eq($sformatf("dot_m%0d_count", m), dout_q.size(), 6);
      for (int j = 0; j < 6; j++)
        check_out($sformatf("dot_m%0d_%0d", m, j), j, em[j], ed[j], j == 5, t0 + 2 + j + 3);
      clear_q();
    end
    bus.mode = 1'b0;

    // One-cycle gap after 4 beats, then a full line.
    for (int c = 0; c < 4; c++) begin
      beat(1'b1, dot_px(c), 8'd0, 8'd0, t);
      if (c == 2) t2 = t;
    end
    idle(1);
    for (int c = 0; c < 8; c++) begin
      beat(1'b1, dot_px(c), 8'd0, 8'd0, t);
      if (c == 0) t0 = t;
    end
    idle(6);
    check_eq("gap_count", dout_q.size(), 8);
    check_out("gap_pre0", 0, 40, 1, 1'b0, t2 + 3);
    check_out("gap_pre1", 1, 40, 2, 1'b0, t2 + 4);
    em = '{40, 40, 40, 0, 0, 0};
    ed = '{1, 2, 3, 0, 0, 0};
    for (int j = 0; j < 6; j++)
      check_out($sformatf("gap_line%0d", j), j + 2, em[j], ed[j], j == 5, t0 + 2 + j + 3);
    clear_q();

    // Reset mid-line with results in flight.
    for (int c = 0; c < 6; c++) beat(1'b1, 8'd255, 8'd0, 8'd0, t);
    @(posedge clk);
    #2;
    check_eq("rst_pre_valid", bus.valid_out, 1);
    check_eq("rst_pre_dout", bus.dout, (255 << 2) | 2);
    rst_n = 1'b0;
    #1;
    check_eq("rst_valid", bus.valid_out, 0);
    check_eq("rst_eol", bus.eol_out, 0);
    check_eq("rst_dout", bus.dout, 0);
    idle(1);
    rst_n = 1'b1;
    clear_q();
    for (int c = 0; c < 3; c++) begin
      beat(1'b1, 8'd255, 8'd0, 8'd0, t);
      if (c == 2) t2 = t;
    end
    idle(6);
    check_eq("rst_after_count", dout_q.size(), 1);
    check_out("rst_after0", 0, 255, 2, 1'b0, t2 + 3);
    clear_q();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sobel_grad_dir.md
Name: sobel_grad_dir

Overview:
Parametrised 3x3 Sobel gradient stage for the canny pipeline. It sits after the 3-line buffer and before non-maximum suppression. It takes three vertically aligned pixel streams and emits, per interior pixel, a saturated gradient magnitude and a 2-bit quantised direction. It adds over the previous generation:
- selectable L1/L-inf magnitude
- divider-free direction binning
- an explicit valid pipeline
- an end-of-line marker

Parameters:
PIC_WIDTH, 250, pixels per line (>=3)
WIDTH, 8, pixel data width
CNT_W, 11, column counter width (2^CNT_W > PIC_WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; asynchronous, active-low
valid_in  input  1  din1..din3 carry one column this cycle; low = line gap
din1  input  WIDTH  top-row pixel (unsigned)
din2  input  WIDTH  middle-row pixel
din3  input  WIDTH  bottom-row pixel
mode  input  1  0: mag=|Gx|+|Gy|; 1: mag=max(|Gx|,|Gy|)
valid_out  output  1  dout valid this cycle
eol_out  output  1  qualifies last dout of a line (only with valid_out)
dout  output  WIDTH+2  {mag[WIDTH-1:0], dir[1:0]}

Behaviour:
- Reset (async, any time incl. mid-line):
  - window regs, cnt, pipeline regs, dout, valid_out and eol_out all go to 0 immediately.
  - First output after release requires 3 fresh columns.
- Window:
  - On each clk edge with valid_in=1, each row shifts: rX_2<=rX_1, rX_1<=rX_0, rX_0<=dinX.
  - Column 0 is the newest (right), column 2 the oldest (left).
  - valid_in=0: window holds.
- Column counter cnt:
  - valid_in=1: increments; wraps to 0 after PIC_WIDTH-1.
  - valid_in=0: cleared to 0. A gap mid-line restarts the line; the partial line is discarded.
- Window-valid:
  - A beat with valid_in=1 and cnt>=2 completes a window.
  - Outputs per complete line = PIC_WIDTH-2; border pixels produce no output.
- Stage 1 (registered), signed WIDTH+3 bits:
  - Gx = (r1_0+2*r2_0+r3_0) - (r1_2+2*r2_2+r3_2)
  - Gy = (r1_2+2*r1_1+r1_0) - (r3_2+2*r3_1+r3_0)
  - mode is sampled here and travels with the data.
- Stage 2 (registered output):
  - ax=|Gx|, ay=|Gy|, unsigned WIDTH+2 bits.
  - mag = mode ? max(ax,ay) : ax+ay, saturated to 2^WIDTH-1.
  - dir, evaluated in order:
    - 0 if ay*256 < ax*106 (|angle|<22.5 deg; covers Gx=Gy=0)
    - 2 if ay*256 > ax*618 (>67.5 deg)
    - 1 if sign(Gx)==sign(Gy) (45 deg)
    - 3 otherwise (135 deg)
  - Constant multiplies only; no dividers.
- Latency:
  - A window-completing beat sampled at edge t gives valid_out=1 after edge t+3, for exactly one cycle.
  - Throughput is 1 pixel/clk; back-to-back lines need no gap.
- eol_out is 1 with the output from the beat where cnt==PIC_WIDTH-1; 0 otherwise.
- valid_out=0: dout holds its last value; eol_out=0.
- valid_in dropping while the pipeline holds data: in-flight results still emerge on schedule.

Test Plan:
- Setup for all scenarios: WIDTH=8, PIC_WIDTH=8, mode=0 unless stated.
- Flat image, all pixels 100, 2 lines back-to-back -> per line 6 valid_out pulses, each dout={0,2'd0}. eol_out on 6th pulse only. First valid_out 3 edges after 3rd input beat.
- Vertical step, columns 0-3=0 and 4-7=255 on all rows -> outputs for newest column 4 and 5: Gx=1020, mag saturates 255, dir 0. All other outputs mag 0.
- Horizontal edge, din1=255, din2=din3=0 every beat -> every output Gy=1020, Gx=0, mag 255, dir 2.
- Single pixel 20 at column 2 of din1, all else 0 -> expected outputs:
  - k=2: mag 40, dir 1
  - k=3: mag 40, dir 2
  - k=4: mag 40, dir 3
  - k>=5: mag 0
  - Repeat with mode=1: mags 20 / 40 / 20.
- valid_in low for 1 cycle after 4 beats, then 8 beats -> the 2 results from the first 4 beats still emerge on schedule. No output from beats 1-2 after resume; exactly 6 outputs follow, eol on the last.
- rst_n asserted mid-line with results in flight -> valid_out, eol_out and dout are 0 before the next clk edge. After release, no output until 3 new columns are accepted.
